// File: rtl/press_pkg.sv
// press_pkg: shared definitions for the press classifier.
//   KIND_SHORT / KIND_LONG : event kind encoding on the event stream
//   ch_idx_w(n)            : width of a channel index for n channels (min 1)
package press_pkg;

  localparam logic KIND_SHORT = 1'b0;
  localparam logic KIND_LONG  = 1'b1;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/press_classifier_if.sv
// press_classifier_if: classified-press event stream.
//   event_valid : an event is presented
//   event_ch    : channel of the presented event
//   event_long  : presented event is long (KIND_LONG) or short (KIND_SHORT)
//   event_ready : consumer accepts the event
// Handshake: an event transfers on a clock edge where event_valid && event_ready.
// While event_valid && !event_ready the source keeps event_valid high and holds
// event_ch, except that a newly pending lower-index channel may take priority.
interface press_classifier_if #(
  parameter int CH_W = 2
);
  logic            event_valid;
  logic [CH_W-1:0] event_ch;
  logic            event_long;
  logic            event_ready;

  modport master (output event_valid, output event_ch, output event_long, input event_ready);
  modport slave  (input event_valid, input event_ch, input event_long, output event_ready);
endinterface

// File: rtl/press_channel.sv
// press_channel: one button input.
//   2-FF synchroniser -> optional debounce -> press-length counter -> classify
//   on release.
//   Optional feature macro: PRESS_DEBOUNCE_EN (stability filter on the level).
// Ports:
//   clk, rst    : clock, async active-high reset
//   in          : raw asynchronous button level (1 = pressed)
//   short_o     : registered one-cycle pulse, short press released
//   long_o      : registered one-cycle pulse, long press released
//   held_o      : registered level, press currently held >= LONG_TICKS
//   rel_o       : combinational release strobe (same edge that loads the pulses)
//   rel_kind_o  : kind of that release (KIND_SHORT / KIND_LONG)
module press_channel
  import press_pkg::*;
#(
  parameter int LONG_TICKS     = 150_000_000,
  parameter int DEBOUNCE_TICKS = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic short_o,
  output logic long_o,
  output logic held_o,
  output logic rel_o,
  output logic rel_kind_o
);

  localparam int CNT_W = $clog2(LONG_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LONG_TICKS);

  logic s1_q, s1_d, s2_q, s2_d;
  logic lvl;
  logic lvl_dly_q, lvl_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic short_q, short_d, long_q, long_d, held_q, held_d;
  logic is_long;

`ifdef PRESS_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_TICKS + 1);
  logic            filt_q, filt_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;

  // The accepted level follows s2 only after s2 has disagreed with it for
  // DEBOUNCE_TICKS consecutive cycles; any agreement restarts the count.
  always_comb begin
    filt_d   = filt_q;
    db_cnt_d = '0;
    if (s2_q != filt_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_TICKS - 1)) begin
        filt_d = s2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q   <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      filt_q   <= filt_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = s2_q;
`endif

  // The counter saturates at LONG_TICKS, so "count >= LONG_TICKS" is an equality.
  assign is_long    = (cnt_q == CNT_MAX);
  assign rel_o      = lvl_dly_q & ~lvl;
  assign rel_kind_o = is_long ? KIND_LONG : KIND_SHORT;

  always_comb begin
    s1_d      = in;
    s2_d      = s1_q;
    lvl_dly_d = lvl;
    cnt_d     = '0;
    if (lvl) begin
      cnt_d = is_long ? cnt_q : cnt_q + 1'b1;
    end
    short_d = rel_o & ~is_long;
    long_d  = rel_o & is_long;
    held_d  = lvl & is_long;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      lvl_dly_q <= 1'b0;
      cnt_q     <= '0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      lvl_dly_q <= lvl_dly_d;
      cnt_q     <= cnt_d;
      short_q   <= short_d;
      long_q    <= long_d;
      held_q    <= held_d;
    end
  end

  assign short_o = short_q;
  assign long_o  = long_q;
  assign held_o  = held_q;

endmodule

// File: rtl/press_classifier.sv
// press_classifier: CHANNELS button inputs classified as short/long presses.
//   Per-channel pulses plus a single event stream of pending presses,
//   presented lowest channel first.
//   Optional feature macro: PRESS_DEBOUNCE_EN (debounce filter per channel).
// Ports:
//   clk, rst : clock, async active-high reset
//   in       : raw button levels, 1 = pressed
//   short_o  : per-channel one-cycle pulse, short press released
//   long_o   : per-channel one-cycle pulse, long press released
//   held_o   : per-channel level, press held >= LONG_TICKS
//   ovf_o    : sticky, a pending event was overwritten before consumption
//   ev       : event stream (valid/ready), master side
module press_classifier
  import press_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int LONG_TICKS     = 150_000_000,
  parameter int DEBOUNCE_TICKS = 500_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] short_o,
  output logic [CHANNELS-1:0] long_o,
  output logic [CHANNELS-1:0] held_o,
  output logic                ovf_o,
  press_classifier_if.master  ev
);

  localparam int CH_W = ch_idx_w(CHANNELS);

  logic [CHANNELS-1:0] rel, rel_kind;
  logic [CHANNELS-1:0] pending_q, pending_d, kind_q, kind_d, clr;
  logic                ovf_q, ovf_d;
  logic [CH_W-1:0]     sel;
  logic                any_pending;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    press_channel #(
      .LONG_TICKS     (LONG_TICKS),
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .in         (in[g]),
      .short_o    (short_o[g]),
      .long_o     (long_o[g]),
      .held_o     (held_o[g]),
      .rel_o      (rel[g]),
      .rel_kind_o (rel_kind[g])
    );
  end

  assign any_pending = |pending_q;

  // Lowest pending index wins; scanning downward leaves the lowest one in sel.
  always_comb begin
    sel = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pending_q[i]) sel = CH_W'(i);
    end
  end

  // A release in the same cycle as the handshake on that channel wins the
  // pending bit and is not an overflow, since the old event was consumed.
  always_comb begin
    clr = '0;
    if (any_pending && ev.event_ready) clr[sel] = 1'b1;
    pending_d = (pending_q & ~clr) | rel;
    for (int i = 0; i < CHANNELS; i++) begin
      kind_d[i] = rel[i] ? rel_kind[i] : kind_q[i];
    end
    ovf_d = ovf_q | (|(rel & pending_q & ~clr));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      kind_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      kind_q    <= kind_d;
      ovf_q     <= ovf_d;
    end
  end

  assign ev.event_valid = any_pending;
  assign ev.event_ch    = sel;
  assign ev.event_long  = kind_q[sel];
  assign ovf_o          = ovf_q;

endmodule

// File: tb/tb_press_classifier.sv
// tb_press_classifier: randomized + directed bench for press_classifier
// (CHANNELS=4, LONG_TICKS=8, debounce off). The reference model works from
// the raw input history: a press lasting D cycles is long iff D >= 8, its
// pulse appears 3 edges after the falling input, and the event stream follows
// the lowest-pending-first / set-wins / sticky-overflow rules.
module tb_press_classifier;
  import press_pkg::*;

  localparam int CHANNELS   = 4;
  localparam int LONG_TICKS = 8;
  localparam int CH_W       = 2;

  // ---------------- clock / reset / DUT ----------------
  logic                clk = 1'b0;
  logic                rst;
  logic [CHANNELS-1:0] in_r;
  logic [CHANNELS-1:0] short_o, long_o, held_o;
  logic                ovf_o;

  press_classifier_if #(.CH_W(CH_W)) ev_if();

  press_classifier #(
    .CHANNELS       (CHANNELS),
    .LONG_TICKS     (LONG_TICKS),
    .DEBOUNCE_TICKS (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in_r),
    .short_o (short_o),
    .long_o  (long_o),
    .held_o  (held_o),
    .ovf_o   (ovf_o),
    .ev      (ev_if)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct {
    int ch;
    bit is_long;
    int due;
  } pulse_t;

  pulse_t exp_q[$];
  int     cyc    = 0;
  int     errors = 0;
  int     checks = 0;

  logic [31:0] hist [CHANNELS];  // bit0 = latest sampled input level
  int          run  [CHANNELS];  // cycles the current press has lasted
  bit          rel_v[CHANNELS];
  bit          rel_k[CHANNELS];
  int          rel_due[CHANNELS];
  bit          m_pend[CHANNELS];
  bit          m_kind[CHANNELS];
  bit          m_ovf;

  // model temporaries
  bit     m_any;
  int     m_lo;
  bit     m_clr[CHANNELS];
  bit     s_now;
  pulse_t p;

  function automatic int lowest_pend();
    for (int i = 0; i < CHANNELS; i++) if (m_pend[i]) return i;
    return 0;
  endfunction

  function automatic bit any_pend();
    for (int i = 0; i < CHANNELS; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model (advances on each edge) ----------------
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      m_ovf = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        hist[i] = '0; run[i] = 0; rel_v[i] = 1'b0;
        m_pend[i] = 1'b0; m_kind[i] = 1'b0;
      end
    end else begin
      // handshake seen at this edge
      m_any = any_pend();
      m_lo  = lowest_pend();
      for (int i = 0; i < CHANNELS; i++) m_clr[i] = m_any && ev_if.event_ready && (i == m_lo);
      for (int i = 0; i < CHANNELS; i++) begin
        if (rel_v[i] && rel_due[i] == cyc) begin
          if (m_pend[i] && !m_clr[i]) m_ovf = 1'b1;
          m_pend[i] = 1'b1;
          m_kind[i] = rel_k[i];
          rel_v[i]  = 1'b0;
        end else if (m_clr[i]) begin
          m_pend[i] = 1'b0;
        end
      end
      // input history: a fall becomes a pulse two cycles from now
      for (int i = 0; i < CHANNELS; i++) begin
        s_now = in_r[i];
        if (hist[i][0] && !s_now) begin
          p.ch = i; p.is_long = (run[i] >= LONG_TICKS); p.due = cyc + 2;
          exp_q.push_back(p);
          rel_v[i] = 1'b1; rel_k[i] = p.is_long; rel_due[i] = cyc + 2;
          run[i] = 0;
        end else if (s_now) begin
          run[i]++;
        end
        hist[i] = {hist[i][30:0], s_now};
      end
    end
  end

  // ---------------- monitor (samples on the falling edge) ----------------
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_short", int'(short_o), 0);
      chk("rst_long", int'(long_o), 0);
      chk("rst_held", int'(held_o), 0);
      chk("rst_valid", int'(ev_if.event_valid), 0);
      chk("rst_ch", int'(ev_if.event_ch), 0);
      chk("rst_evlong", int'(ev_if.event_long), 0);
      chk("rst_ovf", int'(ovf_o), 0);
    end else begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        chk("missed_pulse_ch", -1, exp_q[0].ch);
        void'(exp_q.pop_front());
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (short_o[i] || long_o[i]) begin
          chk("pulse_exclusive", int'(short_o[i] & long_o[i]), 0);
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse_ch", i, -1);
          end else begin
            p = exp_q.pop_front();
            chk("pulse_ch", i, p.ch);
            chk("pulse_long", int'(long_o[i]), int'(p.is_long));
            chk("pulse_cycle", cyc, p.due);
          end
        end
        chk("held", int'(held_o[i]), int'(&hist[i][10:2]));
      end
      chk("event_valid", int'(ev_if.event_valid), int'(any_pend()));
      if (any_pend()) begin
        chk("event_ch", int'(ev_if.event_ch), lowest_pend());
        chk("event_long", int'(ev_if.event_long), int'(m_kind[lowest_pend()]));
      end
      chk("ovf", int'(ovf_o), int'(m_ovf));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int ch, input int dur, input int gap);
    in_r[ch] = 1'b1;
    step(dur);
    in_r[ch] = 1'b0;
    step(gap);
  endtask

  // ---------------- stimulus ----------------
  int left[CHANNELS];

  initial begin
    rst = 1'b1;
    in_r = '0;
    ev_if.event_ready = 1'b0;
    step(3);
    rst = 1'b0;
    step(2);

    // short, long, and the 7/8 threshold with a ready consumer
    ev_if.event_ready = 1'b1;
    press(0, 3, 6);
    press(2, 20, 6);
    press(0, 7, 6);
    press(1, 8, 6);

    // simultaneous releases on ch1/ch3 held back by ready=0
    ev_if.event_ready = 1'b0;
    in_r[1] = 1'b1; in_r[3] = 1'b1;
    step(5);
    in_r[1] = 1'b0; in_r[3] = 1'b0;
    step(8);
    ev_if.event_ready = 1'b1;
    step(6);

    // overwrite of a pending event on ch0
    ev_if.event_ready = 1'b0;
    press(0, 3, 4);
    press(0, 10, 6);
    ev_if.event_ready = 1'b1;
    step(4);

    // reset mid-press, released during reset: no pulse
    in_r[2] = 1'b1;
    step(5);
    rst = 1'b1;
    step(2);
    in_r[2] = 1'b0;
    step(2);
    rst = 1'b0;
    step(10);

    // reset mid-press, still held afterwards: a fresh press
    in_r[2] = 1'b1;
    step(4);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(3);
    in_r[2] = 1'b0;
    step(8);

    // randomized presses and consumer stalls
    for (int i = 0; i < CHANNELS; i++) left[i] = $urandom_range(1, 10);
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (left[i] == 0) begin
          in_r[i] = ~in_r[i];
          left[i] = in_r[i] ? $urandom_range(1, 14) : $urandom_range(1, 6);
        end else begin
          left[i]--;
        end
      end
      ev_if.event_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end

    // drain
    in_r = '0;
    ev_if.event_ready = 1'b1;
    step(20);
    chk("drain_pulses_left", exp_q.size(), 0);
    chk("drain_valid", int'(ev_if.event_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    checks++;
    $display("FAIL timeout: got running expected finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/press_classifier.md
# press_classifier

Multi-channel successor to the single-button save/lock press detector. Each of CHANNELS asynchronous button inputs is synchronised and optionally debounced, and its press length is measured. On release, a press is classified as short or long. Per-channel one-cycle pulses are produced, and classified presses are also queued into a single valid/ready event stream for the safe controller FSM.

## Interface
- CHANNELS, 4: number of independent button inputs (1..16)
- LONG_TICKS, 150_000_000: held cycles at or above which a press is long (3 s at 50 MHz)
- DEBOUNCE_TICKS, 500_000: stable cycles required before a level change is accepted (used only with PRESS_DEBOUNCE_EN)
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- in  input  CHANNELS  raw button levels, asynchronous, 1 = pressed
- short_o  output  CHANNELS  one-cycle pulse per channel: short press released
- long_o  output  CHANNELS  one-cycle pulse per channel: long press released
- held_o  output  CHANNELS  level: press currently held ≥ LONG_TICKS
- event_valid  output  1  queued event available
- event_ch  output  $clog2(CHANNELS) (min 1)  channel of presented event
- event_long  output  1  presented event is long
- event_ready  input  1  consumer accepts event
- ovf_o  output  1  sticky: event overwritten before being consumed

## Operation
- Per channel: 2-FF synchroniser s1 <= in, s2 <= s1. Accepted level `lvl` = s2 (debounce off), or the filtered s2 (debounce on). `lvl_d` = lvl delayed one cycle.
- Counter width $clog2(LONG_TICKS+1).
  - While lvl=1: counter increments each cycle and saturates at LONG_TICKS (no wrap).
  - When lvl=0: counter clears to 0.
- Release = lvl_d=1 && lvl=0. At that edge:
  - long_o[i] <= (count ≥ LONG_TICKS)
  - short_o[i] <= !(count ≥ LONG_TICKS)
  - counter <= 0
- Pulses are registered and last exactly one cycle. short_o[i] and long_o[i] are never high together.
- held_o[i] is registered: 1 while lvl=1 && count == LONG_TICKS. It drops with the release edge.
- Event queue: per-channel pending[i] and kind[i].
  - A release sets pending[i] and loads kind[i].
  - event_valid = |pending. event_ch = lowest pending index. event_long = kind[event_ch].
  - event_valid && event_ready clears pending[event_ch] at the clock edge.
- Boundary cases:
  - New release on a channel that is already pending: kind is overwritten and ovf_o is set. ovf_o is cleared only by rst.
  - Set and clear on the same channel in the same cycle: the set wins, pending stays 1, kind takes the new value, and ovf_o is not set.
  - Simultaneous releases on several channels: all are latched and presented lowest-index first, one per accepted handshake.
  - event_valid is not withdrawn and event_ch does not change while valid && !ready, unless a lower-index channel becomes pending.
- Reset mid-press: all state clears. A button still held after reset deasserts is treated as a fresh press whose count starts from 0.

## Timing
- Reset values: short_o=0, long_o=0, held_o=0, event_valid=0, event_ch=0, event_long=0, ovf_o=0. s1, s2, lvl_d, counters, pending and kind are all 0.
- Input rise to lvl=1: 2 edges (debounce off).
- Release to pulse: in falls → s2 falls 2 edges later → pulse high after the next edge. Total 3 edges.
- Pulse to event_valid: same edge.
- Press duration in counted cycles = number of cycles lvl was 1.

## Configuration
- PRESS_DEBOUNCE_EN defined:
  - Per-channel stability counter of width $clog2(DEBOUNCE_TICKS+1).
  - lvl takes s2 only after s2 has differed from lvl for DEBOUNCE_TICKS consecutive cycles. Any bounce restarts the count.
  - Adds DEBOUNCE_TICKS cycles of latency to both edges.
- Undefined: lvl = s2, DEBOUNCE_TICKS is ignored, and no filter logic is generated.

## Structure
- Package press_pkg: event kind constants (KIND_SHORT=0, KIND_LONG=1) and a width helper function for the channel index.
- Sub-module press_channel: synchroniser, optional debounce, counter, classification, short/long/held outputs. Instantiated CHANNELS times via generate.
- The top level holds the pending/kind arrays, the lowest-index priority select, the handshake and ovf_o.

## Test plan
- CHANNELS=4, LONG_TICKS=8, debounce off. Hold in[0] for 3 cycles → short_o[0] pulses once, 3 edges after the fall. Event (ch 0, long=0) is presented and cleared on ready.
- Hold in[2] for 20 cycles → held_o[2] rises when count reaches 8 and stays high. On release: long_o[2] pulses, held_o[2] falls, event (ch 2, long=1).
- Boundary: hold for exactly 7 lvl-cycles → short. Hold for exactly 8 → long.
- Release ch1 and ch3 in the same cycle with event_ready=0 for 5 cycles, then 1 → events appear as ch1 then ch3 on consecutive cycles. event_valid stays high until both are consumed.
- Two releases on ch0 with ready=0 → ovf_o=1, and the event shows the second kind. Pulse rst mid-press on ch2 → all outputs 0, no pulse on the later release unless lvl rises again after reset.
- With PRESS_DEBOUNCE_EN, DEBOUNCE_TICKS=4: 3-cycle glitches → no pulses. A clean 12-cycle press → exactly one short pulse, delayed 4 extra cycles.
